// File: rtl/multi_debounce.sv
// Multi-channel push-button conditioner: synchroniser, stability qualifier,
// debounced level, press/release strobes and optional hold-to-repeat strobes.
module multi_debounce #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned COUNT_WIDTH   = 22,
  parameter int unsigned STABLE_COUNT  = 4194303,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACTIVE_LOW_IN = 0,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_PERIOD = 0,
  parameter int unsigned REPEAT_WIDTH  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] repeat_o,
  output logic                any_press_o
);

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(STABLE_COUNT - 1);

  logic [CHANNELS-1:0]    pin_level;
  logic [CHANNELS-1:0]    sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]    s;
  logic [COUNT_WIDTH-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0]    differ;
  logic [CHANNELS-1:0]    accept;

  assign pin_level = (ACTIVE_LOW_IN != 0) ? ~button : button;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_level;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A change is taken on the edge that completes STABLE_COUNT differing cycles.
  always_comb begin
    differ = s ^ level_o;
    accept = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      accept[ch] = differ[ch] && (cnt[ch] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) cnt[ch] <= '0;
      level_o   <= '0;
      press_o   <= '0;
      release_o <= '0;
    end else begin
      level_o   <= level_o ^ accept;
      press_o   <= accept & s;
      release_o <= accept & ~s;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        if (!differ[ch] || accept[ch]) cnt[ch] <= '0;
        else                           cnt[ch] <= cnt[ch] + COUNT_WIDTH'(1);
      end
    end
  end

  assign any_press_o = |press_o;

  if (REPEAT_DELAY > 0) begin : g_repeat
    // rc holds (cycles since press - 1) so the strobe lands exactly REPEAT_DELAY
    // cycles after press_o; reload keeps the spacing at REPEAT_PERIOD.
    localparam logic [REPEAT_WIDTH-1:0] RC_LAST   = REPEAT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_WIDTH-1:0] RC_RELOAD = REPEAT_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REPEAT_WIDTH-1:0] rc [CHANNELS];
    logic [CHANNELS-1:0]     rep_hit;

    always_comb begin
      rep_hit = '0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        rep_hit[ch] = level_o[ch] && !accept[ch] && (rc[ch] == RC_LAST);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) rc[ch] <= '0;
        repeat_o <= '0;
      end else begin
        repeat_o <= rep_hit;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
          if (!level_o[ch] || accept[ch]) rc[ch] <= '0;
          else if (rep_hit[ch])           rc[ch] <= RC_RELOAD;
          else                            rc[ch] <= rc[ch] + REPEAT_WIDTH'(1);
        end
      end
    end
  end else begin : g_no_repeat
    assign repeat_o = '0;
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: a per-cycle vector table for press, bounce
// and release, then hand sequences for repeat, simultaneous presses and reset.
module tb_multi_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] button;
  logic [3:0] level_o, press_o, release_o, repeat_o;
  logic       any_press_o;

  int n_checks = 0;
  int n_fail   = 0;

  multi_debounce #(
    .CHANNELS      (4),
    .COUNT_WIDTH   (4),
    .STABLE_COUNT  (4),
    .SYNC_STAGES   (2),
    .ACTIVE_LOW_IN (0),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3),
    .REPEAT_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .button      (button),
    .level_o     (level_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .repeat_o    (repeat_o),
    .any_press_o (any_press_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rep;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic [3:0] btn, input logic [3:0] lvl,
                              input logic [3:0] prs, input logic [3:0] rel,
                              input logic [3:0] rep, input logic any);
    vec_t v;
    v.btn = btn; v.lvl = lvl; v.prs = prs; v.rel = rel; v.rep = rep; v.any = any;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Row i: outputs expected after edge i, then btn applied until edge i+1.
    // A change applied after edge e shows up after edge e+6.
    add(3, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(2, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    add(1, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(2, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 1'b1);
    add(1, 4'b0010, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(2, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    add(3, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    add(2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    rst_n  = 1'b0;
    button = 4'b1111;
    repeat (3) tick();
    chk("reset_outputs", {level_o, press_o, release_o, repeat_o, any_press_o}, 32'd0);
    button = 4'b0000;
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      chk($sformatf("table_row%0d", i),
          {level_o, press_o, release_o, repeat_o, any_press_o},
          {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].rep, vecs[i].any});
      button = vecs[i].btn;
    end

    // Hold-to-repeat on channel 2; drop it so the release is taken on the
    // very edge the fourth repeat would have fired.
    tick();
    button[2] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("rep_press", {press_o, any_press_o}, (n == 6) ? {4'b0100, 1'b1} : 5'd0);
    end
    for (int c = 1; c <= 22; c++) begin
      logic [3:0] rep_exp, rel_exp;
      rep_exp = (c == 10 || c == 13 || c == 16) ? 4'b0100 : 4'b0000;
      rel_exp = (c == 19) ? 4'b0100 : 4'b0000;
      tick();
      chk($sformatf("rep_c%0d", c), {level_o, press_o, repeat_o, release_o},
          {(c < 19) ? 4'b0100 : 4'b0000, 4'b0000, rep_exp, rel_exp});
      if (c == 13) button[2] = 1'b0;
    end

    // Simultaneous presses on channels 0 and 3.
    button = 4'b1001;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk("sim_press", {press_o, any_press_o}, (n == 6) ? {4'b1001, 1'b1} : 5'd0);
    end
    button = 4'b0000;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("sim_release", {press_o, release_o}, (n == 6) ? {4'b0000, 4'b1001} : 8'd0);
    end

    // Staggered by one cycle: two separate any_press_o cycles.
    tick();
    button[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      logic [4:0] e;
      e = (n == 6) ? {4'b0001, 1'b1} : (n == 7) ? {4'b1000, 1'b1} : 5'd0;
      tick();
      chk($sformatf("stag_n%0d", n), {press_o, any_press_o}, e);
      if (n == 1) button[3] = 1'b1;
    end
    button = 4'b0000;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk("stag_release", release_o, (n == 6) ? 4'b1001 : 4'b0000);
    end

    // Reset mid-qualification: channel 3 qualified, channel 1 two counts in.
    tick();
    button[3] = 1'b1;
    for (int n = 1; n <= 6; n++) tick();
    chk("rst_pre_level", level_o, 4'b1000);
    button[1] = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("rst_pre_press", press_o, 4'b0000);
    end
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async", {level_o, press_o, release_o, repeat_o, any_press_o}, 32'd0);
    for (int n = 1; n <= 2; n++) begin
      tick();
      chk("rst_hold", {level_o, press_o, release_o, repeat_o, any_press_o}, 32'd0);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      logic [8:0] e;
      e = (n == 6) ? {4'b1010, 4'b1010, 1'b1} :
          (n == 7) ? {4'b1010, 4'b0000, 1'b0} : 9'd0;
      tick();
      chk($sformatf("rst_requal_n%0d", n), {level_o, press_o, any_press_o}, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
